// File: rtl/up_down_mod_counter.sv
// ============================================================================
// up_down_mod_counter : prescaled modulo-(MAX_VAL+1) up/down counter with
// wrap/saturate boundary, parallel load, terminal-count pulse, sticky overflow.
// Rev 1.0
// ============================================================================
`default_nettype none

module up_down_mod_counter #(
  parameter int          WIDTH    = 4,
  parameter int unsigned MAX_VAL  = int'((64'd1 << WIDTH) - 64'd1),
  parameter int          PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] c_MAX = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;

  logic             w_pre_done;
  logic             w_step;
  logic             w_at_top;
  logic             w_at_bot;
  logic             w_boundary;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_val;

  // Prescaler exists only when more than one enabled cycle makes a step.
  if (PRESCALE > 1) begin : g_prescaler
    localparam int              c_PW       = $clog2(PRESCALE);
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(PRESCALE - 1);
    localparam logic [c_PW-1:0] c_PRE_ONE  = c_PW'(1);

    logic [c_PW-1:0] r_pre;

    always_ff @(posedge clock) begin
      if (reset || load) begin
        r_pre <= '0;
      end else if (enable) begin
        r_pre <= (r_pre == c_PRE_LAST) ? '0 : r_pre + c_PRE_ONE;
      end
    end

    assign w_pre_done = (r_pre == c_PRE_LAST);
  end else begin : g_no_prescaler
    assign w_pre_done = 1'b1;
  end

  assign w_step     = enable && !load && w_pre_done;
  assign w_at_top   = (r_count == c_MAX);
  assign w_at_bot   = (r_count == '0);
  assign w_boundary = w_step && (up_down ? w_at_top : w_at_bot);
  assign w_load_val = (load_value > c_MAX) ? c_MAX : load_value;

  always_comb begin
    w_next = r_count;
    if (up_down) begin
      if (!w_at_top)     w_next = r_count + c_ONE;
      else if (!sat_mode) w_next = '0;
    end else begin
      if (!w_at_bot)     w_next = r_count - c_ONE;
      else if (!sat_mode) w_next = c_MAX;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (load) begin
      r_count <= w_load_val;
      r_tc    <= 1'b0;
    end else begin
      r_tc <= w_boundary;
      // A coincident boundary event outranks clear_ovf.
      if (w_boundary)     r_ovf <= 1'b1;
      else if (clear_ovf) r_ovf <= 1'b0;
      if (w_step)         r_count <= w_next;
    end
  end

  assign count_out = r_count;
  assign tc        = r_tc;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_up_down_mod_counter.sv
// Testbench for up_down_mod_counter: PRESCALE=1 (A) and PRESCALE=3 (B) instances,
// MAX_VAL=9, sharing stimulus; expected {count,tc,ovf} flow through scoreboard queues.
`default_nettype none

module tb_up_down_mod_counter;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       up;
    logic       sat;
    logic       ld;
    logic [3:0] lv;
    logic       clr;
  } stim_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       up_down = 1'b0;
  logic       sat_mode = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic       clear_ovf = 1'b0;
  logic [3:0] cnt_a, cnt_b;
  logic       tc_a, tc_b, ovf_a, ovf_b;

  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] qa[$];
  logic [5:0] qb[$];

  always #5 clock = ~clock;

  up_down_mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) u_dut_a (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
    .sat_mode(sat_mode), .load(load), .load_value(load_value),
    .clear_ovf(clear_ovf), .count_out(cnt_a), .tc(tc_a), .ovf(ovf_a)
  );

  up_down_mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) u_dut_b (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
    .sat_mode(sat_mode), .load(load), .load_value(load_value),
    .clear_ovf(clear_ovf), .count_out(cnt_b), .tc(tc_b), .ovf(ovf_b)
  );

  task automatic drive(input stim_t s);
    reset      = s.rst;
    enable     = s.en;
    up_down    = s.up;
    sat_mode   = s.sat;
    load       = s.ld;
    load_value = s.lv;
    clear_ovf  = s.clr;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0});
  endtask

  task automatic test_reset();
    logic [5:0] e;
    qa.push_back(6'd0);
    qb.push_back(6'd0);
    drive('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd7, 1'b1});
    e = qa.pop_front();
    n_checks++;
    if ({cnt_a, tc_a, ovf_a} !== e) begin
      n_errors++;
      $display("FAIL reset A: got %0d/%0b/%0b expected %0d/%0b/%0b", cnt_a, tc_a, ovf_a, e[5:2], e[1], e[0]);
    end
    e = qb.pop_front();
    n_checks++;
    if ({cnt_b, tc_b, ovf_b} !== e) begin
      n_errors++;
      $display("FAIL reset B: got %0d/%0b/%0b expected %0d/%0b/%0b", cnt_b, tc_b, ovf_b, e[5:2], e[1], e[0]);
    end
  endtask

  // Up-count through the modulus with wrap; the 10th step is the 9->0 boundary.
  task automatic test_wrap();
    logic [5:0] e;
    do_reset();
    for (int i = 1; i <= 11; i++) begin
      qa.push_back({4'(i % 10), (i == 10) ? 1'b1 : 1'b0, (i >= 10) ? 1'b1 : 1'b0});
      drive('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0});
      e = qa.pop_front();
      n_checks++;
      if ({cnt_a, tc_a, ovf_a} !== e) begin
        n_errors++;
        $display("FAIL wrap[%0d]: got %0d/%0b/%0b expected %0d/%0b/%0b", i, cnt_a, tc_a, ovf_a, e[5:2], e[1], e[0]);
      end
    end
  endtask

  // Down-count saturating at 0: every step is a boundary event.
  task automatic test_sat_down();
    logic [5:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      qa.push_back({4'd0, (i < 3) ? 1'b1 : 1'b0, 1'b1});
      drive('{1'b0, (i < 3) ? 1'b1 : 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0});
      e = qa.pop_front();
      n_checks++;
      if ({cnt_a, tc_a, ovf_a} !== e) begin
        n_errors++;
        $display("FAIL sat_down[%0d]: got %0d/%0b/%0b expected %0d/%0b/%0b", i, cnt_a, tc_a, ovf_a, e[5:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_prescale();
    logic       en_s[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] cb_s[7] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
    logic [5:0] e;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      qb.push_back({cb_s[i], 2'b00});
      drive('{1'b0, en_s[i], 1'b1, 1'b0, 1'b0, 4'd0, 1'b0});
      e = qb.pop_front();
      n_checks++;
      if ({cnt_b, tc_b, ovf_b} !== e) begin
        n_errors++;
        $display("FAIL prescale[%0d]: got %0d/%0b/%0b expected %0d/%0b/%0b", i, cnt_b, tc_b, ovf_b, e[5:2], e[1], e[0]);
      end
    end
  endtask

  // Load clamps to MAX_VAL, restarts B's prescaler, and leaves ovf untouched.
  task automatic test_load();
    stim_t st[7] = '{
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd12, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5,  1'b0}};
    logic [5:0] ea[7] = '{{4'd1, 2'b00}, {4'd2, 2'b00}, {4'd9, 2'b00}, {4'd0, 2'b11},
                          {4'd1, 2'b01}, {4'd2, 2'b01}, {4'd5, 2'b01}};
    logic [5:0] eb[7] = '{{4'd0, 2'b00}, {4'd0, 2'b00}, {4'd9, 2'b00}, {4'd9, 2'b00},
                          {4'd9, 2'b00}, {4'd0, 2'b11}, {4'd5, 2'b01}};
    logic [5:0] e;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      qa.push_back(ea[i]);
      qb.push_back(eb[i]);
      drive(st[i]);
      e = qa.pop_front();
      n_checks++;
      if ({cnt_a, tc_a, ovf_a} !== e) begin
        n_errors++;
        $display("FAIL load A[%0d]: got %0d/%0b/%0b expected %0d/%0b/%0b", i, cnt_a, tc_a, ovf_a, e[5:2], e[1], e[0]);
      end
      e = qb.pop_front();
      n_checks++;
      if ({cnt_b, tc_b, ovf_b} !== e) begin
        n_errors++;
        $display("FAIL load B[%0d]: got %0d/%0b/%0b expected %0d/%0b/%0b", i, cnt_b, tc_b, ovf_b, e[5:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_clear_ovf();
    stim_t st[5] = '{
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1},
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1}};
    logic [5:0] ea[5] = '{{4'd9, 2'b00}, {4'd0, 2'b11}, {4'd9, 2'b01}, {4'd0, 2'b11}, {4'd0, 2'b00}};
    logic [5:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      qa.push_back(ea[i]);
      drive(st[i]);
      e = qa.pop_front();
      n_checks++;
      if ({cnt_a, tc_a, ovf_a} !== e) begin
        n_errors++;
        $display("FAIL clear_ovf[%0d]: got %0d/%0b/%0b expected %0d/%0b/%0b", i, cnt_a, tc_a, ovf_a, e[5:2], e[1], e[0]);
      end
    end
  endtask

  // Reset beats load/enable at count 5, then reset mid-prescale restarts B's full period.
  task automatic test_reset_mid();
    stim_t st[10] = '{
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0}};
    logic [5:0] ea[10] = '{{4'd9, 2'b00}, {4'd0, 2'b11}, {4'd5, 2'b01}, {4'd0, 2'b00}, {4'd1, 2'b00},
                           {4'd2, 2'b00}, {4'd0, 2'b00}, {4'd1, 2'b00}, {4'd2, 2'b00}, {4'd3, 2'b00}};
    logic [5:0] eb[10] = '{{4'd9, 2'b00}, {4'd9, 2'b00}, {4'd5, 2'b00}, {4'd0, 2'b00}, {4'd0, 2'b00},
                           {4'd0, 2'b00}, {4'd0, 2'b00}, {4'd0, 2'b00}, {4'd0, 2'b00}, {4'd1, 2'b00}};
    logic [5:0] e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      qa.push_back(ea[i]);
      qb.push_back(eb[i]);
      drive(st[i]);
      e = qa.pop_front();
      n_checks++;
      if ({cnt_a, tc_a, ovf_a} !== e) begin
        n_errors++;
        $display("FAIL reset_mid A[%0d]: got %0d/%0b/%0b expected %0d/%0b/%0b", i, cnt_a, tc_a, ovf_a, e[5:2], e[1], e[0]);
      end
      e = qb.pop_front();
      n_checks++;
      if ({cnt_b, tc_b, ovf_b} !== e) begin
        n_errors++;
        $display("FAIL reset_mid B[%0d]: got %0d/%0b/%0b expected %0d/%0b/%0b", i, cnt_b, tc_b, ovf_b, e[5:2], e[1], e[0]);
      end
    end
  endtask

  // Back-to-back steps with direction/mode flipping every cycle.
  task automatic test_back_to_back();
    logic       up_s[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       sat_s[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [5:0] ea[7] = '{{4'd9, 2'b11}, {4'd8, 2'b01}, {4'd9, 2'b01}, {4'd9, 2'b11},
                          {4'd8, 2'b01}, {4'd9, 2'b01}, {4'd0, 2'b11}};
    logic [5:0] e;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      qa.push_back(ea[i]);
      drive('{1'b0, 1'b1, up_s[i], sat_s[i], 1'b0, 4'd0, 1'b0});
      e = qa.pop_front();
      n_checks++;
      if ({cnt_a, tc_a, ovf_a} !== e) begin
        n_errors++;
        $display("FAIL back_to_back[%0d]: got %0d/%0b/%0b expected %0d/%0b/%0b", i, cnt_a, tc_a, ovf_a, e[5:2], e[1], e[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_sat_down();
    test_prescale();
    test_load();
    test_clear_ovf();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
